// File: rtl/norm_pkg.sv
// Shared definitions for the 16-bit shift normalizer.
// Holds widths, mode constants and the FSM state encoding.
package norm_pkg;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    localparam logic NORM_LEFT  = 1'b0;
    localparam logic NORM_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/norm_stage.sv
// One binary-search stage of the normalizer (combinational).
// Ports: w_i word, m_i mode, k_i stage index (n = 2^k);
//        w_o next word, take_o = the n-bit edge slice was zero.
module norm_stage
    import norm_pkg::*;
(
    input  logic [WIDTH-1:0] w_i,
    input  logic             m_i,
    input  logic [1:0]       k_i,
    output logic [WIDTH-1:0] w_o,
    output logic             take_o
);

    logic [4:0] n;
    logic [4:0] rest;
    logic       hi_zero;
    logic       lo_zero;

    assign n    = 5'd1 << k_i;
    assign rest = 5'd16 - n;

    // Edge slice is zero when nothing survives shifting
    // the rest of the word out of the way.
    assign hi_zero = ((w_i >> rest) == 16'h0000);
    assign lo_zero = ((w_i << rest) == 16'h0000);

    assign take_o = (m_i == NORM_RIGHT) ? lo_zero : hi_zero;

    always_comb begin
        w_o = w_i;
        if (take_o) begin
            if (m_i == NORM_RIGHT) w_o = w_i >> n;
            else                   w_o = w_i << n;
        end
    end

endmodule

// File: rtl/shift_normalizer16.sv
// Sequential normalizer: shifts a word until bit 15 (left) or bit 0
// (right) is set and reports the shift. Ports: valid/ready input side
// (in_data, in_mode), valid/ready output side (out_data/shamt/zero).
module shift_normalizer16
    import norm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output logic             out_zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic             m_q, m_d;
    logic [SHW-1:0]   a_q, a_d;
    logic [1:0]       k_q, k_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] od_q, od_d;
    logic [SHW-1:0]   os_q, os_d;
    logic             oz_q, oz_d;

    logic [WIDTH-1:0] st_w;
    logic             st_take;

    norm_stage u_stage (
        .w_i    (w_q),
        .m_i    (m_q),
        .k_i    (k_q),
        .w_o    (st_w),
        .take_o (st_take)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_shamt = os_q;
    assign out_zero  = oz_q;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        m_d     = m_q;
        a_d     = a_q;
        k_d     = k_q;
        ov_d    = ov_q;
        od_d    = od_q;
        os_d    = os_q;
        oz_d    = oz_q;
        unique case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (in_valid) begin
                    w_d     = in_data;
                    m_d     = in_mode;
                    a_d     = '0;
                    oz_d    = (in_data == 16'h0000);
                    k_d     = 2'd3;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_d      = st_w;
                a_d[k_q] = st_take;
                k_d      = k_q - 2'd1;
                if (k_q == 2'd0) state_d = ST_DONE;
            end
            ST_DONE: begin
                // First DONE cycle publishes the result registers;
                // after that they hold until the consumer takes them.
                if (!ov_q) begin
                    ov_d = 1'b1;
                    od_d = w_q;
                    os_d = a_q;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            w_q     <= '0;
            m_q     <= 1'b0;
            a_q     <= '0;
            k_q     <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            os_q    <= '0;
            oz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            m_q     <= m_d;
            a_q     <= a_d;
            k_q     <= k_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            os_q    <= os_d;
            oz_q    <= oz_d;
        end
    end

endmodule

// File: tb/tb_shift_normalizer16.sv
// Self-checking bench for shift_normalizer16.
// Directed cases plus random words against a count-the-zeros model.
module tb_shift_normalizer16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_shamt;
    logic        out_zero;

    int total_cnt = 0;
    int pass_cnt  = 0;

    shift_normalizer16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shamt (out_shamt),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Walk the word one bit at a time until the target edge bit is set.
    task automatic ref_norm(input logic [15:0] d, input logic m,
                            output logic [15:0] od, output logic [3:0] sh);
        int cnt;
        od  = d;
        cnt = 0;
        if (d == 16'h0000) begin
            sh = 4'hF;
        end else begin
            while ((m ? od[0] : od[15]) == 1'b0) begin
                od = m ? (od >> 1) : (od << 1);
                cnt++;
            end
            sh = cnt[3:0];
        end
    endtask

    task automatic expect_res(input logic [15:0] d, input logic m,
                              input string tag);
        logic [15:0] ed;
        logic [3:0]  es;
        logic [15:0] back;
        ref_norm(d, m, ed, es);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 4) chk({tag, " early_valid"}, 32'(out_valid), 32'd0);
        end
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " data"}, 32'(out_data), 32'(ed));
        chk({tag, " shamt"}, 32'(out_shamt), 32'(es));
        chk({tag, " zero"}, 32'(out_zero), 32'(d == 16'h0000));
        back = m ? (out_data << out_shamt) : (out_data >> out_shamt);
        chk({tag, " roundtrip"}, 32'(back), 32'(d));
        chk({tag, " busy_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic take_res(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " drop_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [15:0] d, input logic m,
                        input string tag);
        chk({tag, " ready"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_mode  = 1'($urandom);
        expect_res(d, m, tag);
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_shamt", 32'(out_shamt), 32'd0);
        chk("rst out_zero", 32'(out_zero), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init ready", 32'(in_ready), 32'd1);

        send(16'h0013, 1'b0, "left13");
        take_res("left13");
        send(16'h0A00, 1'b1, "rightA00");
        take_res("rightA00");
        send(16'h0000, 1'b0, "zeroL");
        take_res("zeroL");
        send(16'h0000, 1'b1, "zeroR");
        take_res("zeroR");
        send(16'h8000, 1'b0, "l8000");
        take_res("l8000");
        send(16'h8000, 1'b1, "r8000");
        take_res("r8000");
        send(16'h0001, 1'b1, "r0001");
        take_res("r0001");

        // Backpressure with a new request waiting.
        send(16'h0340, 1'b0, "bp");
        held      = out_data;
        in_valid  = 1'b1;
        in_data   = 16'h00F0;
        in_mode   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp hold_valid", 32'(out_valid), 32'd1);
            chk("bp hold_data", 32'(out_data), 32'(held));
            chk("bp hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release", 32'(out_valid), 32'd0);
        chk("bp idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
        in_mode  = 1'b0;
        expect_res(16'h00F0, 1'b1, "bp2");
        take_res("bp2");

        // Reset while BUSY on stage 2.
        chk("rstmid ready", 32'(in_ready), 32'd1);
        in_data  = 16'h0123;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid valid", 32'(out_valid), 32'd0);
        chk("rstmid ready0", 32'(in_ready), 32'd0);
        chk("rstmid data", 32'(out_data), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid ready1", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("rstmid no_replay", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        send(16'h0001, 1'b0, "post_rst");
        take_res("post_rst");

        // Random words, biased toward many leading/trailing zeros.
        for (int i = 0; i < 24; i++) begin
            rd = 16'($urandom);
            if ((i % 2) == 0) rd = rd >> $urandom_range(0, 15);
            else              rd = rd << $urandom_range(0, 15);
            send(rd, 1'($urandom), "rand");
            take_res("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
